rv_decompress: RTL and testbench

- Pipeline stage directly downstream of the instruction fetch stage. It consumes the fetch buffer's instruction, pc and pc_next words.
- Expands RVC 16-bit encodings into their 32-bit RV32I equivalents and flags illegal encodings.
- Registers the result with a valid/stall handshake toward the decode stage.
- Owns the fetch-side stall signal, which controls when the fetch buffer pops.

---
 rtl/rv_pkg.sv | 43 ++++
 rtl/rv_rvc_expand.sv | 130 +++++++++++++
 rtl/rv_decompress.sv | 111 +++++++++++
 tb/tb_rv_decompress.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I opcode constants and RVC quadrant / funct3 codes used by the
// instruction decompression stage.
package rv_pkg;

  // RV32I major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // RVC quadrants (instruction bits [1:0])
  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;

  // RVC funct3 (instruction bits [15:13]) per quadrant
  localparam logic [2:0] C0_ADDI4SPN = 3'b000;
  localparam logic [2:0] C0_LW       = 3'b010;
  localparam logic [2:0] C0_SW       = 3'b110;
  localparam logic [2:0] C1_ADDI     = 3'b000;
  localparam logic [2:0] C1_JAL      = 3'b001;
  localparam logic [2:0] C1_LI       = 3'b010;
  localparam logic [2:0] C1_LUI      = 3'b011;
  localparam logic [2:0] C1_ALU      = 3'b100;
  localparam logic [2:0] C1_J        = 3'b101;
  localparam logic [2:0] C1_BEQZ     = 3'b110;
  localparam logic [2:0] C1_BNEZ     = 3'b111;
  localparam logic [2:0] C2_SLLI     = 3'b000;
  localparam logic [2:0] C2_LWSP     = 3'b010;
  localparam logic [2:0] C2_JR       = 3'b100;
  localparam logic [2:0] C2_SWSP     = 3'b110;

  // Compressed 3-bit register field -> x8..x15
  function automatic logic [4:0] creg(input logic [2:0] r);
    return {2'b01, r};
  endfunction

endpackage

// File: rtl/rv_rvc_expand.sv
// Purely combinational RV32C -> RV32I expander. Illegal or unsupported
// encodings raise o_illegal and return the raw halfword zero-extended.
module rv_rvc_expand
  import rv_pkg::*;
(
  input  logic [15:0] i_instr,
  output logic [31:0] o_instr,
  output logic        o_illegal
);

  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs2;
  logic [4:0]  p97;
  logic [4:0]  p42;
  logic [11:0] imm6_sx;
  logic [10:1] jofs;
  logic        imm6_zero;

  assign f3        = i_instr[15:13];
  assign rd        = i_instr[11:7];
  assign rs2       = i_instr[6:2];
  assign p97       = creg(i_instr[9:7]);
  assign p42       = creg(i_instr[4:2]);
  assign imm6_sx   = {{7{i_instr[12]}}, i_instr[6:2]};
  assign imm6_zero = ({i_instr[12], i_instr[6:2]} == 6'd0);
  // C.J / C.JAL offset[10:1] unscrambled from the RVC jump format
  assign jofs      = {i_instr[8], i_instr[10:9], i_instr[6], i_instr[7],
                      i_instr[2], i_instr[11], i_instr[5:3]};

  // Decode quadrant/funct3 and assemble the equivalent 32-bit word
  always_comb begin
    o_instr   = 32'h0;
    o_illegal = 1'b0;
    case (i_instr[1:0])
      Q0: begin
        case (f3)
          C0_ADDI4SPN: begin
            o_instr   = {2'b00, i_instr[10:7], i_instr[12:11], i_instr[5], i_instr[6],
                         2'b00, 5'd2, 3'b000, p42, OP_IMM};
            o_illegal = (i_instr[12:5] == 8'h00);
          end
          C0_LW:   o_instr = {5'b0, i_instr[5], i_instr[12:10], i_instr[6], 2'b00,
                              p97, 3'b010, p42, OP_LOAD};
          C0_SW:   o_instr = {5'b0, i_instr[5], i_instr[12], p42, p97, 3'b010,
                              i_instr[11:10], i_instr[6], 2'b00, OP_STORE};
          default: o_illegal = 1'b1;
        endcase
      end
      Q1: begin
        case (f3)
          C1_ADDI: o_instr = {imm6_sx, rd, 3'b000, rd, OP_IMM};
          C1_JAL:  o_instr = {i_instr[12], jofs, i_instr[12], {8{i_instr[12]}}, 5'd1, OP_JAL};
          C1_J:    o_instr = {i_instr[12], jofs, i_instr[12], {8{i_instr[12]}}, 5'd0, OP_JAL};
          C1_LI:   o_instr = {imm6_sx, 5'd0, 3'b000, rd, OP_IMM};
          C1_LUI: begin
            o_illegal = imm6_zero;
            if (rd == 5'd2) begin
              o_instr = {{3{i_instr[12]}}, i_instr[4:3], i_instr[5], i_instr[2], i_instr[6],
                         4'b0000, 5'd2, 3'b000, 5'd2, OP_IMM};
            end else begin
              o_instr = {{15{i_instr[12]}}, i_instr[6:2], rd, OP_LUI};
            end
          end
          C1_ALU: begin
            case (i_instr[11:10])
              2'b00: begin
                o_instr   = {6'b000000, i_instr[12], i_instr[6:2], p97, 3'b101, p97, OP_IMM};
                o_illegal = i_instr[12];
              end
              2'b01: begin
                o_instr   = {6'b010000, i_instr[12], i_instr[6:2], p97, 3'b101, p97, OP_IMM};
                o_illegal = i_instr[12];
              end
              2'b10: o_instr = {imm6_sx, p97, 3'b111, p97, OP_IMM};
              default: begin
                // funct3=100 with bit 12 set is reserved on RV32
                o_illegal = i_instr[12];
                case (i_instr[6:5])
                  2'b00:   o_instr = {7'b0100000, p42, p97, 3'b000, p97, OP_OP};
                  2'b01:   o_instr = {7'b0000000, p42, p97, 3'b100, p97, OP_OP};
                  2'b10:   o_instr = {7'b0000000, p42, p97, 3'b110, p97, OP_OP};
                  default: o_instr = {7'b0000000, p42, p97, 3'b111, p97, OP_OP};
                endcase
              end
            endcase
          end
          // C.BEQZ/C.BNEZ differ only in bit 13, which becomes funct3[0]
          default: o_instr = {{4{i_instr[12]}}, i_instr[6:5], i_instr[2], 5'd0, p97,
                              2'b00, i_instr[13], i_instr[11:10], i_instr[4:3],
                              i_instr[12], OP_BRANCH};
        endcase
      end
      Q2: begin
        case (f3)
          C2_SLLI: begin
            o_instr   = {6'b000000, i_instr[12], rs2, rd, 3'b001, rd, OP_IMM};
            o_illegal = i_instr[12];
          end
          C2_LWSP: begin
            o_instr   = {4'b0000, i_instr[3:2], i_instr[12], i_instr[6:4], 2'b00,
                         5'd2, 3'b010, rd, OP_LOAD};
            o_illegal = (rd == 5'd0);
          end
          C2_JR: begin
            if (!i_instr[12]) begin
              if (rs2 == 5'd0) begin
                o_instr   = {12'h000, rd, 3'b000, 5'd0, OP_JALR};
                o_illegal = (rd == 5'd0);
              end else begin
                o_instr = {7'b0000000, rs2, 5'd0, 3'b000, rd, OP_OP};
              end
            end else if (rs2 == 5'd0) begin
              if (rd == 5'd0) o_instr = {12'h001, 5'd0, 3'b000, 5'd0, OP_SYSTEM};
              else            o_instr = {12'h000, rd, 3'b000, 5'd1, OP_JALR};
            end else begin
              o_instr = {7'b0000000, rs2, rd, 3'b000, rd, OP_OP};
            end
          end
          C2_SWSP: o_instr = {4'b0000, i_instr[8:7], i_instr[12], rs2, 5'd2, 3'b010,
                              i_instr[11:9], 2'b00, OP_STORE};
          default: o_illegal = 1'b1;
        endcase
      end
      default: o_illegal = 1'b1;
    endcase
    if (o_illegal) o_instr = {16'h0000, i_instr};
  end

endmodule

// File: rtl/rv_decompress.sv
// Decompress stage between fetch and decode: expands RVC encodings, flags
// illegal words and registers the result behind a valid/stall handshake.
module rv_decompress
  import rv_pkg::*;
#(
  parameter int IADDR_SPACE_BITS = 16,
  parameter int EXTENSION_C      = 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_flush,
  input  logic                          i_ready,
  input  logic [31:0]                   i_instruction,
  input  logic [IADDR_SPACE_BITS-1:1]   i_pc,
  input  logic [IADDR_SPACE_BITS-1:1]   i_pc_next,
  output logic                          o_fetch_stall,
  input  logic                          i_stall,
  output logic                          o_valid,
  output logic [31:0]                   o_instruction,
  output logic [IADDR_SPACE_BITS-1:1]   o_pc,
  output logic [IADDR_SPACE_BITS-1:1]   o_pc_next,
  output logic                          o_compressed,
  output logic                          o_illegal
);

  logic                        is_c;
  logic [31:0]                 exp_instr;
  logic                        exp_ill;
  logic [31:0]                 dec_instr;
  logic                        dec_ill;
  logic                        load;

  logic                        valid_d, valid_q;
  logic [31:0]                 instr_d, instr_q;
  logic [IADDR_SPACE_BITS-1:1] pc_d, pc_q;
  logic [IADDR_SPACE_BITS-1:1] pc_next_d, pc_next_q;
  logic                        comp_d, comp_q;
  logic                        ill_d, ill_q;

  rv_rvc_expand u_expand (
    .i_instr   (i_instruction[15:0]),
    .o_instr   (exp_instr),
    .o_illegal (exp_ill)
  );

  assign is_c          = (i_instruction[1:0] != 2'b11);
  assign o_fetch_stall = i_reset | i_flush | (valid_q & i_stall);
  assign load          = !o_fetch_stall;

  // Select passthrough, expanded or rejected word
  always_comb begin
    dec_instr = i_instruction;
    dec_ill   = (i_instruction[6:2] == 5'b11111);
    if (is_c) begin
      if (EXTENSION_C != 0) begin
        dec_instr = exp_instr;
        dec_ill   = exp_ill;
      end else begin
        dec_instr = {16'h0000, i_instruction[15:0]};
        dec_ill   = 1'b1;
      end
    end
  end

  // Next-state for the output register: load, flush-drop or hold
  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    pc_next_d = pc_next_q;
    comp_d    = comp_q;
    ill_d     = ill_q;
    if (load) begin
      valid_d   = i_ready;
      instr_d   = dec_instr;
      pc_d      = i_pc;
      pc_next_d = i_pc_next;
      comp_d    = is_c;
      ill_d     = dec_ill;
    end else if (i_flush) begin
      valid_d   = 1'b0;
    end
  end

  // Output register with synchronous reset to a NOP
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q   <= 1'b0;
      instr_q   <= 32'h0000_0013;
      pc_q      <= '0;
      pc_next_q <= '0;
      comp_q    <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pc_next_q <= pc_next_d;
      comp_q    <= comp_d;
      ill_q     <= ill_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_instruction = instr_q;
  assign o_pc          = pc_q;
  assign o_pc_next     = pc_next_q;
  assign o_compressed  = comp_q;
  assign o_illegal     = ill_q;

endmodule

// File: tb/tb_rv_decompress.sv
// Directed bench for rv_decompress: vector table for the expansion paths,
// hand-written sequences for reset, stall, flush and mid-stream reset.
module tb_rv_decompress;

  localparam int IAW = 16;
  localparam int NV  = 33;

  logic             i_clk = 1'b0;
  logic             i_reset, i_flush, i_ready, i_stall;
  logic [31:0]      i_instruction;
  logic [IAW-1:1]   i_pc, i_pc_next;

  logic             o_fetch_stall, o_valid, o_compressed, o_illegal;
  logic [31:0]      o_instruction;
  logic [IAW-1:1]   o_pc, o_pc_next;

  logic             n_fetch_stall, n_valid, n_compressed, n_illegal;
  logic [31:0]      n_instruction;
  logic [IAW-1:1]   n_pc, n_pc_next;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] exp_instr;
    logic        exp_c;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [NV];

  always #5 i_clk = ~i_clk;

  rv_decompress #(.IADDR_SPACE_BITS(IAW), .EXTENSION_C(1)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_ready(i_ready),
    .i_instruction(i_instruction), .i_pc(i_pc), .i_pc_next(i_pc_next),
    .o_fetch_stall(o_fetch_stall), .i_stall(i_stall), .o_valid(o_valid),
    .o_instruction(o_instruction), .o_pc(o_pc), .o_pc_next(o_pc_next),
    .o_compressed(o_compressed), .o_illegal(o_illegal)
  );

  rv_decompress #(.IADDR_SPACE_BITS(IAW), .EXTENSION_C(0)) dut_nc (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_ready(i_ready),
    .i_instruction(i_instruction), .i_pc(i_pc), .i_pc_next(i_pc_next),
    .o_fetch_stall(n_fetch_stall), .i_stall(i_stall), .o_valid(n_valid),
    .o_instruction(n_instruction), .o_pc(n_pc), .o_pc_next(n_pc_next),
    .o_compressed(n_compressed), .o_illegal(n_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " valid"},   32'(o_valid),       32'h0);
    chk({tag, " instr"},   o_instruction,      32'h0000_0013);
    chk({tag, " pc"},      32'(o_pc),          32'h0);
    chk({tag, " pc_next"}, 32'(o_pc_next),     32'h0);
    chk({tag, " comp"},    32'(o_compressed),  32'h0);
    chk({tag, " ill"},     32'(o_illegal),     32'h0);
    chk({tag, " nc valid"}, 32'(n_valid),      32'h0);
    chk({tag, " nc instr"}, n_instruction,     32'h0000_0013);
    chk({tag, " nc ill"},  32'(n_illegal),     32'h0);
  endtask

  initial begin
    vecs[0]  = '{32'h0010_0093, 32'h0010_0093, 1'b0, 1'b0}; // addi x1,x0,1
    vecs[1]  = '{32'h0000_4501, 32'h0000_0513, 1'b1, 1'b0}; // c.li a0,0
    vecs[2]  = '{32'h0000_852E, 32'h00B0_0533, 1'b1, 1'b0}; // c.mv a0,a1
    vecs[3]  = '{32'h0000_8082, 32'h0000_8067, 1'b1, 1'b0}; // c.jr ra
    vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1}; // all-zero
    vecs[5]  = '{32'h0000_007F, 32'h0000_007F, 1'b0, 1'b1}; // >32-bit prefix
    vecs[6]  = '{32'h0000_0004, 32'h0000_0004, 1'b1, 1'b1}; // addi4spn nzuimm=0
    vecs[7]  = '{32'h0000_6101, 32'h0000_6101, 1'b1, 1'b1}; // addi16sp imm=0
    vecs[8]  = '{32'h0000_6501, 32'h0000_6501, 1'b1, 1'b1}; // c.lui imm=0
    vecs[9]  = '{32'h0000_4002, 32'h0000_4002, 1'b1, 1'b1}; // lwsp rd=0
    vecs[10] = '{32'h0000_8002, 32'h0000_8002, 1'b1, 1'b1}; // jr rs1=0
    vecs[11] = '{32'h0000_1006, 32'h0000_1006, 1'b1, 1'b1}; // slli shamt[5]
    vecs[12] = '{32'h0000_2000, 32'h0000_2000, 1'b1, 1'b1}; // c.fld
    vecs[13] = '{32'h0000_9C01, 32'h0000_9C01, 1'b1, 1'b1}; // q1 reserved
    vecs[14] = '{32'h0000_9002, 32'h0010_0073, 1'b1, 1'b0}; // c.ebreak
    vecs[15] = '{32'h0000_0040, 32'h0041_0413, 1'b1, 1'b0}; // addi4spn s0,4
    vecs[16] = '{32'h0000_41C8, 32'h0045_A503, 1'b1, 1'b0}; // c.lw a0,4(a1)
    vecs[17] = '{32'h0000_C1C8, 32'h00A5_A223, 1'b1, 1'b0}; // c.sw a0,4(a1)
    vecs[18] = '{32'h0000_BFFD, 32'hFFFF_F06F, 1'b1, 1'b0}; // c.j -2
    vecs[19] = '{32'h0000_2009, 32'h0020_00EF, 1'b1, 1'b0}; // c.jal +2
    vecs[20] = '{32'h0000_DC7D, 32'hFE04_0FE3, 1'b1, 1'b0}; // c.beqz s0,-2
    vecs[21] = '{32'h0000_8405, 32'h4014_5413, 1'b1, 1'b0}; // c.srai s0,1
    vecs[22] = '{32'h0000_8C05, 32'h4094_0433, 1'b1, 1'b0}; // c.sub s0,s1
    vecs[23] = '{32'h0000_157D, 32'hFFF5_0513, 1'b1, 1'b0}; // c.addi a0,-1
    vecs[24] = '{32'h0000_6505, 32'h0000_1537, 1'b1, 1'b0}; // c.lui a0,1
    vecs[25] = '{32'h0000_952E, 32'h00B5_0533, 1'b1, 1'b0}; // c.add a0,a1
    vecs[26] = '{32'h0000_9502, 32'h0005_00E7, 1'b1, 1'b0}; // c.jalr a0
    vecs[27] = '{32'h0000_C22A, 32'h00A1_2223, 1'b1, 1'b0}; // c.swsp a0,4
    vecs[28] = '{32'h0000_4512, 32'h0041_2503, 1'b1, 1'b0}; // c.lwsp a0,4
    vecs[29] = '{32'h0000_6141, 32'h0101_0113, 1'b1, 1'b0}; // addi16sp 16
    vecs[30] = '{32'h0000_0506, 32'h0015_1513, 1'b1, 1'b0}; // c.slli a0,1
    vecs[31] = '{32'h0000_987D, 32'hFFF4_7413, 1'b1, 1'b0}; // c.andi s0,-1
    vecs[32] = '{32'hDEAD_4501, 32'h0000_0513, 1'b1, 1'b0}; // upper half ignored

    i_reset = 1'b1; i_flush = 1'b0; i_ready = 1'b0; i_stall = 1'b0;
    i_instruction = 32'h0; i_pc = '0; i_pc_next = '0;

    repeat (2) @(posedge i_clk);
    #1;
    chk_reset("reset");
    chk("reset fetch_stall", 32'(o_fetch_stall), 32'h1);

    i_reset = 1'b0;
    #1;
    chk("idle fetch_stall", 32'(o_fetch_stall), 32'h0);
    @(posedge i_clk); #1;
    chk("idle valid", 32'(o_valid), 32'h0);

    // Back-to-back vectors: one instruction per cycle
    for (int k = 0; k < NV; k++) begin
      i_ready       = 1'b1;
      i_instruction = vecs[k].instr;
      i_pc          = 15'(16 + 2 * k);
      i_pc_next     = 15'(16 + 2 * k + (vecs[k].exp_c ? 1 : 2));
      @(posedge i_clk); #1;
      chk($sformatf("v%0d valid", k), 32'(o_valid), 32'h1);
      chk($sformatf("v%0d instr", k), o_instruction, vecs[k].exp_instr);
      chk($sformatf("v%0d comp", k), 32'(o_compressed), 32'(vecs[k].exp_c));
      chk($sformatf("v%0d ill", k), 32'(o_illegal), 32'(vecs[k].exp_ill));
      chk($sformatf("v%0d pc", k), 32'(o_pc), 32'(16 + 2 * k));
      chk($sformatf("v%0d pc_next", k), 32'(o_pc_next),
          32'(16 + 2 * k + (vecs[k].exp_c ? 1 : 2)));
      chk($sformatf("v%0d nc ill", k), 32'(n_illegal),
          32'(vecs[k].exp_c ? 1'b1 : vecs[k].exp_ill));
    end

    // Stall for 3 cycles: output frozen, fetch stalled, next word not lost
    i_instruction = 32'h0010_0093; i_pc = 15'h40; i_pc_next = 15'h42;
    @(posedge i_clk); #1;
    chk("stall pre instr", o_instruction, 32'h0010_0093);
    i_instruction = 32'h0000_4501; i_pc = 15'h42; i_pc_next = 15'h43;
    i_stall = 1'b1;
    #1;
    chk("stall fetch_stall", 32'(o_fetch_stall), 32'h1);
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk); #1;
      chk($sformatf("stall%0d valid", c), 32'(o_valid), 32'h1);
      chk($sformatf("stall%0d instr", c), o_instruction, 32'h0010_0093);
      chk($sformatf("stall%0d pc", c), 32'(o_pc), 32'h40);
      chk($sformatf("stall%0d fetch_stall", c), 32'(o_fetch_stall), 32'h1);
    end
    i_stall = 1'b0;
    #1;
    chk("release fetch_stall", 32'(o_fetch_stall), 32'h0);
    @(posedge i_clk); #1;
    chk("release instr", o_instruction, 32'h0000_0513);
    chk("release pc", 32'(o_pc), 32'h42);
    chk("release comp", 32'(o_compressed), 32'h1);
    i_ready = 1'b0;
    @(posedge i_clk); #1;
    chk("drain valid", 32'(o_valid), 32'h0);

    // Flush while valid and stalled: flush wins, nothing captured
    i_ready = 1'b1; i_instruction = 32'h0010_0093; i_pc = 15'h50; i_pc_next = 15'h52;
    @(posedge i_clk); #1;
    chk("flush pre valid", 32'(o_valid), 32'h1);
    i_instruction = 32'h0000_4501; i_pc = 15'h52; i_pc_next = 15'h53;
    i_stall = 1'b1; i_flush = 1'b1;
    #1;
    chk("flush fetch_stall", 32'(o_fetch_stall), 32'h1);
    @(posedge i_clk); #1;
    chk("flush valid", 32'(o_valid), 32'h0);
    chk("flush no capture", o_instruction, 32'h0010_0093);
    i_flush = 1'b0; i_stall = 1'b0;
    @(posedge i_clk); #1;
    chk("post flush valid", 32'(o_valid), 32'h1);
    chk("post flush instr", o_instruction, 32'h0000_0513);

    // Reset together with flush mid-stream
    i_instruction = 32'h0000_8082; i_pc = 15'h60; i_pc_next = 15'h61;
    @(posedge i_clk); #1;
    chk("mid pre instr", o_instruction, 32'h0000_8067);
    i_reset = 1'b1; i_flush = 1'b1;
    #1;
    chk("mid fetch_stall", 32'(o_fetch_stall), 32'h1);
    @(posedge i_clk); #1;
    chk_reset("mid reset");
    i_reset = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    @(posedge i_clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
